// File: rtl/gpi_input_conditioner.sv
// Synchronizes and debounces board switches/buttons for the MCS GPI ports,
// and latches sticky button-press and switch-change events until firmware acks them.
module gpi_input_conditioner #(
    parameter int unsigned N_SW            = 8,
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] ack_btn,
    input  logic             ack_sw,
    output logic [N_SW-1:0]  sw_clean,
    output logic [N_BTN-1:0] btn_clean,
    output logic [N_BTN-1:0] btn_event,
    output logic             sw_changed
);

    localparam int unsigned    N_ALL   = N_SW + N_BTN;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Switches occupy the low bits, buttons the high bits of every per-bit vector.
    logic [N_ALL-1:0]            raw;
    logic [N_ALL-1:0]            s1_q;
    logic [N_ALL-1:0]            s2_q;
    logic [N_ALL-1:0]            lvl_q;
    logic [N_ALL-1:0]            lvl_d;
    logic [N_ALL-1:0]            prev_q;
    logic [N_ALL-1:0][CNT_W-1:0] cnt_q;
    logic [N_ALL-1:0][CNT_W-1:0] cnt_d;
    logic [N_BTN-1:0]            btn_event_q;
    logic [N_BTN-1:0]            btn_event_d;
    logic                        sw_changed_q;
    logic                        sw_changed_d;
    logic [N_BTN-1:0]            rise;
    logic                        chg;

    assign raw = {btn_raw, sw_raw};

    // Per-bit debounce: a level is accepted only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        for (int i = 0; i < int'(N_ALL); i++) begin
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    lvl_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Sticky events: a fresh set beats a simultaneous ack so no event is lost.
    always_comb begin
        rise         = lvl_q[N_ALL-1:N_SW] & ~prev_q[N_ALL-1:N_SW];
        chg          = |(lvl_q[N_SW-1:0] ^ prev_q[N_SW-1:0]);
        btn_event_d  = rise | (btn_event_q & ~ack_btn);
        sw_changed_d = chg | (sw_changed_q & ~ack_sw);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            lvl_q        <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            btn_event_q  <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            s1_q         <= raw;
            s2_q         <= s1_q;
            lvl_q        <= lvl_d;
            prev_q       <= lvl_q;
            cnt_q        <= cnt_d;
            btn_event_q  <= btn_event_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    assign sw_clean   = lvl_q[N_SW-1:0];
    assign btn_clean  = lvl_q[N_ALL-1:N_SW];
    assign btn_event  = btn_event_q;
    assign sw_changed = sw_changed_q;

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Bench for gpi_input_conditioner: vector table, directed corner cases and
// randomized traffic checked against a sample-history reference model.
module tb_gpi_input_conditioner;

    localparam int unsigned N_SW  = 8;
    localparam int unsigned N_BTN = 4;
    localparam int unsigned N_ALL = N_SW + N_BTN;
    localparam int unsigned D     = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] ack_btn;
    logic             ack_sw;
    logic [N_SW-1:0]  sw_clean;
    logic [N_BTN-1:0] btn_clean;
    logic [N_BTN-1:0] btn_event;
    logic             sw_changed;

    int checks = 0;
    int errors = 0;

    gpi_input_conditioner #(
        .N_SW(N_SW), .N_BTN(N_BTN), .DEBOUNCE_CYCLES(D), .CNT_W(3)
    ) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .btn_raw(btn_raw),
        .ack_btn(ack_btn), .ack_sw(ack_sw), .sw_clean(sw_clean),
        .btn_clean(btn_clean), .btn_event(btn_event), .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted when the last D synchronized samples all disagree with it.
    bit [N_ALL-1:0] m_s1, m_s2, m_q, m_qp;
    bit             m_hist [N_ALL][D];
    bit [N_BTN-1:0] m_ev;
    bit             m_chg;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_q = '0; m_qp = '0; m_ev = '0; m_chg = 1'b0;
            for (int i = 0; i < int'(N_ALL); i++)
                for (int k = 0; k < int'(D); k++) m_hist[i][k] = 1'b0;
        end else begin
            bit all_diff;
            for (int b = 0; b < int'(N_BTN); b++)
                m_ev[b] = (m_q[N_SW+b] && !m_qp[N_SW+b]) || (m_ev[b] && !ack_btn[b]);
            m_chg = (m_q[N_SW-1:0] != m_qp[N_SW-1:0]) || (m_chg && !ack_sw);
            m_qp = m_q;
            for (int i = 0; i < int'(N_ALL); i++) begin
                for (int k = int'(D) - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = m_s2[i];
                all_diff = 1'b1;
                for (int k = 0; k < int'(D); k++)
                    if (m_hist[i][k] == m_q[i]) all_diff = 1'b0;
                if (all_diff) m_q[i] = ~m_q[i];
            end
            m_s2 = m_s1;
            m_s1 = {btn_raw, sw_raw};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge, then compare every output against the model.
    task automatic cycle();
        @(posedge clk);
        #1;
        chk("model_sw_clean", 32'(sw_clean), 32'(m_q[N_SW-1:0]));
        chk("model_btn_clean", 32'(btn_clean), 32'(m_q[N_ALL-1:N_SW]));
        chk("model_btn_event", 32'(btn_event), 32'(m_ev));
        chk("model_sw_changed", 32'(sw_changed), 32'(m_chg));
    endtask

    typedef struct {
        logic             rst;
        logic [N_SW-1:0]  sw;
        logic [N_BTN-1:0] btn;
        logic [N_BTN-1:0] ackb;
        logic             acks;
        logic [N_SW-1:0]  e_sw;
        logic [N_BTN-1:0] e_btn;
        logic [N_BTN-1:0] e_ev;
        logic             e_chg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic rst, input logic [7:0] sw, input logic [3:0] btn,
                       input logic [3:0] ackb, input logic acks, input logic [7:0] e_sw,
                       input logic [3:0] e_btn, input logic [3:0] e_ev, input logic e_chg);
        vec_t v;
        v = '{rst, sw, btn, ackb, acks, e_sw, e_btn, e_ev, e_chg};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        // Reset with everything high, release, then let everything settle back low.
        add(2, 1, 8'hFF, 4'hF, 4'h0, 0, 8'h00, 4'h0, 4'h0, 0);
        add(5, 0, 8'hFF, 4'hF, 4'h0, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 0, 8'hFF, 4'hF, 4'h0, 0, 8'hFF, 4'hF, 4'h0, 0);
        add(1, 0, 8'hFF, 4'hF, 4'h0, 0, 8'hFF, 4'hF, 4'hF, 1);
        add(1, 0, 8'hFF, 4'hF, 4'hF, 1, 8'hFF, 4'hF, 4'h0, 0);
        add(5, 0, 8'h00, 4'h0, 4'h0, 0, 8'hFF, 4'hF, 4'h0, 0);
        add(1, 0, 8'h00, 4'h0, 4'h0, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 0, 8'h00, 4'h0, 4'h0, 0, 8'h00, 4'h0, 4'h0, 1);
        add(1, 0, 8'h00, 4'h0, 4'h0, 1, 8'h00, 4'h0, 4'h0, 0);

        sw_raw = '0; btn_raw = '0; ack_btn = '0; ack_sw = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[n]) begin
            reset = vecs[n].rst; sw_raw = vecs[n].sw; btn_raw = vecs[n].btn;
            ack_btn = vecs[n].ackb; ack_sw = vecs[n].acks;
            cycle();
            chk($sformatf("vec%0d_sw_clean", n), 32'(sw_clean), 32'(vecs[n].e_sw));
            chk($sformatf("vec%0d_btn_clean", n), 32'(btn_clean), 32'(vecs[n].e_btn));
            chk($sformatf("vec%0d_btn_event", n), 32'(btn_event), 32'(vecs[n].e_ev));
            chk($sformatf("vec%0d_sw_changed", n), 32'(sw_changed), 32'(vecs[n].e_chg));
        end
        ack_btn = '0; ack_sw = 1'b0;

        // Bounce on btn[1]: runs of 2 samples never reach the acceptance count.
        for (int k = 0; k < 28; k++) begin
            if (k < 20 && k % 2 == 0) btn_raw[1] = ~btn_raw[1];
            cycle();
            chk("bounce_clean1", 32'(btn_clean[1]), 32'd0);
            chk("bounce_event1", 32'(btn_event[1]), 32'd0);
        end

        // Clean press and release on btn[2], then ack.
        btn_raw[2] = 1'b1;
        repeat (5) cycle();
        chk("press_clean2_early", 32'(btn_clean[2]), 32'd0);
        cycle();
        chk("press_clean2_edge6", 32'(btn_clean[2]), 32'd1);
        chk("press_event2_edge6", 32'(btn_event[2]), 32'd0);
        cycle();
        chk("press_event2_edge7", 32'(btn_event[2]), 32'd1);
        btn_raw[2] = 1'b0;
        repeat (5) cycle();
        chk("release_clean2_early", 32'(btn_clean[2]), 32'd1);
        cycle();
        chk("release_clean2", 32'(btn_clean[2]), 32'd0);
        chk("release_event2_held", 32'(btn_event[2]), 32'd1);
        ack_btn[2] = 1'b1;
        cycle();
        ack_btn[2] = 1'b0;
        chk("ack_event2", 32'(btn_event[2]), 32'd0);

        // Ack coinciding with the rise on btn[3]: the set wins, a later ack clears.
        btn_raw[3] = 1'b1;
        repeat (6) cycle();
        chk("coll_clean3", 32'(btn_clean[3]), 32'd1);
        chk("coll_event3_pre", 32'(btn_event[3]), 32'd0);
        ack_btn[3] = 1'b1;
        cycle();
        chk("coll_event3_set_wins", 32'(btn_event[3]), 32'd1);
        cycle();
        ack_btn[3] = 1'b0;
        chk("coll_event3_cleared", 32'(btn_event[3]), 32'd0);
        btn_raw[3] = 1'b0;
        repeat (8) cycle();

        // Reset in the middle of a btn[0] debounce discards the partial count.
        btn_raw[0] = 1'b1;
        repeat (4) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midrst_clean_zero", 32'(btn_clean), 32'd0);
        repeat (5) cycle();
        chk("midrst_clean0_early", 32'(btn_clean[0]), 32'd0);
        cycle();
        chk("midrst_clean0_edge6", 32'(btn_clean[0]), 32'd1);
        btn_raw[0] = 1'b0;
        repeat (8) cycle();
        ack_btn = 4'hF;
        cycle();
        ack_btn = '0;

        // Multi-bit switch step, ack, then a single-bit re-toggle.
        sw_raw = 8'hA5;
        repeat (5) cycle();
        chk("multi_sw_early", 32'(sw_clean), 32'h00);
        cycle();
        chk("multi_sw_edge6", 32'(sw_clean), 32'hA5);
        chk("multi_chg_edge6", 32'(sw_changed), 32'd0);
        cycle();
        chk("multi_chg_edge7", 32'(sw_changed), 32'd1);
        cycle();
        chk("multi_chg_held", 32'(sw_changed), 32'd1);
        ack_sw = 1'b1;
        cycle();
        ack_sw = 1'b0;
        chk("multi_chg_acked", 32'(sw_changed), 32'd0);
        cycle();
        chk("multi_chg_single", 32'(sw_changed), 32'd0);
        sw_raw[0] = 1'b0;
        repeat (6) cycle();
        chk("retoggle_sw", 32'(sw_clean), 32'hA4);
        cycle();
        chk("retoggle_chg", 32'(sw_changed), 32'd1);

        // Randomized traffic with slow toggles, random acks and rare resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < int'(N_SW); i++)
                if ($urandom_range(5) == 0) sw_raw[i] = ~sw_raw[i];
            for (int i = 0; i < int'(N_BTN); i++) begin
                if ($urandom_range(5) == 0) btn_raw[i] = ~btn_raw[i];
                ack_btn[i] = ($urandom_range(3) == 0);
            end
            ack_sw = ($urandom_range(3) == 0);
            reset = ($urandom_range(299) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
